// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 host controller: register map, STATUS layout, TX states and
// host-to-device frame layout.
package ps2_pkg;

   localparam logic RegData   = 1'b0;
   localparam logic RegStatus = 1'b1;

   localparam int unsigned StatusRxAvail   = 0;
   localparam int unsigned StatusRxOverflow = 1;
   localparam int unsigned StatusParityErr = 2;
   localparam int unsigned StatusTxBusy    = 3;
   localparam int unsigned StatusTxError   = 4;

   // Frame bits shifted after the start bit: 8 data (LSB first), parity, stop.
   localparam int unsigned Ps2DataBits  = 8;
   localparam int unsigned Ps2ParityIdx = Ps2DataBits;
   localparam int unsigned Ps2StopIdx   = Ps2DataBits + 1;
   localparam int unsigned Ps2BitIdxW   = 4;

   typedef enum logic [2:0] {
      TxIdle,
      TxInhibit,
      TxRequest,
      TxSend,
      TxAck
   } tx_state_e;

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_scancode_fifo.sv
// Synchronous scancode FIFO; a push into a full FIFO succeeds only when a pop happens in the
// same cycle.
module ps2_scancode_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [7:0]            push_data,
   output logic [7:0]            head,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int unsigned Depth = 2 ** DEPTH_LOG2;

   logic [7:0]            mem_q [Depth];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  do_push, do_pop;

   assign empty   = (count_q == '0);
   // Count never exceeds Depth, so its MSB alone marks full.
   assign full    = count_q[DEPTH_LOG2];
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/ps2_host_controller.sv
// PS/2 host port: scancode FIFO behind a DATA/STATUS bus slave, plus the host-to-device command
// sequencer, which is built only when PS2_HOST_TX_EN is defined.
module ps2_host_controller
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH_LOG2 = 4,
   parameter int unsigned INHIBIT_CYCLES  = 5000,
   parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       bus_address,
   input  logic       bus_read,
   input  logic       bus_write,
   input  logic [7:0] bus_data_in,
   output logic [7:0] bus_data_out,
   output logic       irq,
   input  logic [7:0] rx_scancode,
   input  logic       scancode_ready_set,
   input  logic       parity_error,
   input  logic       edge_found,
   input  logic       ps2_data,
   output logic       ps2_clock_oe,
   output logic       ps2_data_oe
);

   logic                     status_rd, data_rd;
   logic                     tx_busy, tx_error_set;
   logic                     fifo_push, fifo_full, fifo_empty;
   logic [7:0]               fifo_head;
   logic [FIFO_DEPTH_LOG2:0] fifo_count;
   logic                     rx_overflow_q, rx_parity_err_q, tx_error_q, irq_enable_q;
   logic [7:0]               bus_data_out_q, status;
   logic                     unused_count;

   assign status_rd = bus_read & (bus_address == RegStatus);
   assign data_rd   = bus_read & (bus_address == RegData);
   // Receive bytes arriving while a command is in flight are the device echoing noise; drop them.
   assign fifo_push = scancode_ready_set & ~tx_busy;

   ps2_scancode_fifo #(
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push),
      .pop       (data_rd),
      .push_data (rx_scancode),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign unused_count = ^fifo_count;

   always_comb begin
      status                   = '0;
      status[StatusRxAvail]    = ~fifo_empty;
      status[StatusRxOverflow] = rx_overflow_q;
      status[StatusParityErr]  = rx_parity_err_q;
      status[StatusTxBusy]     = tx_busy;
      status[StatusTxError]    = tx_error_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_overflow_q   <= 1'b0;
         rx_parity_err_q <= 1'b0;
         tx_error_q      <= 1'b0;
         irq_enable_q    <= 1'b0;
         bus_data_out_q  <= '0;
      end else begin
         if (status_rd) begin
            rx_overflow_q   <= 1'b0;
            rx_parity_err_q <= 1'b0;
            tx_error_q      <= 1'b0;
         end
         // New events override the read-clear so none are lost.
         if (fifo_push && fifo_full && !data_rd) rx_overflow_q <= 1'b1;
         if (fifo_push && parity_error)         rx_parity_err_q <= 1'b1;
         if (tx_error_set)                      tx_error_q <= 1'b1;
         if (bus_write && bus_address == RegStatus) irq_enable_q <= bus_data_in[0];
         if (status_rd) begin
            bus_data_out_q <= status;
         end else if (data_rd) begin
            bus_data_out_q <= fifo_empty ? 8'h00 : fifo_head;
         end
      end
   end

   assign bus_data_out = bus_data_out_q;
   assign irq          = ~fifo_empty & irq_enable_q;

`ifdef PS2_HOST_TX_EN

   localparam int unsigned InhibitW = $clog2(INHIBIT_CYCLES + 1);
   localparam int unsigned TimerW   = $clog2(TIMEOUT_CYCLES + 1);

   tx_state_e             state_q, state_d;
   logic [InhibitW-1:0]   inhibit_cnt_q, inhibit_cnt_d;
   logic [TimerW-1:0]     timer_q, timer_d;
   logic [Ps2BitIdxW-1:0] bit_idx_q, bit_idx_d;
   logic [8:0]            tx_frame_q, tx_frame_d;
   logic                  data_oe_q, data_oe_d;
   logic                  edge_q, ps2_edge, timed_out;

   assign ps2_edge  = edge_q & ~edge_found;
   assign timed_out = (state_q != TxIdle) && !ps2_edge &&
                      (timer_q == TimerW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d       = state_q;
      inhibit_cnt_d = inhibit_cnt_q;
      bit_idx_d     = bit_idx_q;
      tx_frame_d    = tx_frame_q;
      data_oe_d     = data_oe_q;
      tx_error_set  = 1'b0;
      unique case (state_q)
         TxIdle: begin
            if (bus_write && bus_address == RegData) begin
               tx_frame_d    = {odd_parity(bus_data_in), bus_data_in};
               inhibit_cnt_d = '0;
               state_d       = TxInhibit;
            end
         end
         TxInhibit: begin
            if (inhibit_cnt_q == InhibitW'(INHIBIT_CYCLES - 1)) begin
               data_oe_d = 1'b1;
               state_d   = TxRequest;
            end else begin
               inhibit_cnt_d = inhibit_cnt_q + 1'b1;
            end
         end
         TxRequest: begin
            bit_idx_d = '0;
            state_d   = TxSend;
         end
         TxSend: begin
            if (ps2_edge) begin
               if (bit_idx_q == Ps2BitIdxW'(Ps2StopIdx)) begin
                  data_oe_d = 1'b0;
                  state_d   = TxAck;
               end else begin
                  data_oe_d = ~tx_frame_q[bit_idx_q];
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
         TxAck: begin
            if (ps2_edge) begin
               tx_error_set = ps2_data;
               state_d      = TxIdle;
            end
         end
         default: state_d = TxIdle;
      endcase
      if (timed_out) begin
         data_oe_d    = 1'b0;
         tx_error_set = 1'b1;
         state_d      = TxIdle;
      end
   end

   always_comb begin
      if (state_q == TxIdle || state_d != state_q || ps2_edge) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= TxIdle;
         inhibit_cnt_q <= '0;
         timer_q       <= '0;
         bit_idx_q     <= '0;
         tx_frame_q    <= '0;
         data_oe_q     <= 1'b0;
         edge_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         inhibit_cnt_q <= inhibit_cnt_d;
         timer_q       <= timer_d;
         bit_idx_q     <= bit_idx_d;
         tx_frame_q    <= tx_frame_d;
         data_oe_q     <= data_oe_d;
         edge_q        <= edge_found;
      end
   end

   assign tx_busy      = (state_q != TxIdle);
   assign ps2_clock_oe = (state_q == TxInhibit);
   assign ps2_data_oe  = data_oe_q;

`else

   logic unused_tx;

   assign tx_busy      = 1'b0;
   assign tx_error_set = 1'b0;
   assign ps2_clock_oe = 1'b0;
   assign ps2_data_oe  = 1'b0;
   assign unused_tx    = ^{edge_found, ps2_data, bus_data_in[7:1], INHIBIT_CYCLES, TIMEOUT_CYCLES};

`endif

endmodule

// File: tb/tb_ps2_host_controller.sv
// Directed bench for ps2_host_controller; TX scenarios run when PS2_HOST_TX_EN is defined.
module tb_ps2_host_controller;

   localparam int unsigned DepthLog2 = 4;
   localparam int unsigned Inhibit   = 20;
   localparam int unsigned Timeout   = 300;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       bus_address = 1'b0;
   logic       bus_read = 1'b0;
   logic       bus_write = 1'b0;
   logic [7:0] bus_data_in = '0;
   logic [7:0] bus_data_out;
   logic       irq;
   logic [7:0] rx_scancode = '0;
   logic       scancode_ready_set = 1'b0;
   logic       parity_error = 1'b0;
   logic       edge_found = 1'b0;
   logic       ps2_data = 1'b1;
   logic       ps2_clock_oe;
   logic       ps2_data_oe;

   int errors = 0;
   int checks = 0;

   ps2_host_controller #(
      .FIFO_DEPTH_LOG2 (DepthLog2),
      .INHIBIT_CYCLES  (Inhibit),
      .TIMEOUT_CYCLES  (Timeout)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .bus_address        (bus_address),
      .bus_read           (bus_read),
      .bus_write          (bus_write),
      .bus_data_in        (bus_data_in),
      .bus_data_out       (bus_data_out),
      .irq                (irq),
      .rx_scancode        (rx_scancode),
      .scancode_ready_set (scancode_ready_set),
      .parity_error       (parity_error),
      .edge_found         (edge_found),
      .ps2_data           (ps2_data),
      .ps2_clock_oe       (ps2_clock_oe),
      .ps2_data_oe        (ps2_data_oe)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic bus_rd(input logic addr);
      tick();
      bus_address = addr;
      bus_read = 1'b1;
      tick();
      bus_read = 1'b0;
   endtask

   task automatic bus_wr(input logic addr, input logic [7:0] data);
      tick();
      bus_address = addr;
      bus_data_in = data;
      bus_write = 1'b1;
      tick();
      bus_write = 1'b0;
   endtask

   task automatic push(input logic [7:0] code, input logic perr);
      tick();
      rx_scancode = code;
      parity_error = perr;
      scancode_ready_set = 1'b1;
      tick();
      scancode_ready_set = 1'b0;
      parity_error = 1'b0;
   endtask

   task automatic ps2_clock_pulse();
      tick();
      edge_found = 1'b1;
      tick();
      tick();
      edge_found = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      repeat (3) tick();
      reset = 1'b0;
      tick();
      checks++;
      if (bus_data_out !== 8'h00 || irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: data_out=%h irq=%b, required 00/0", bus_data_out, irq);
      end
      checks++;
      if (ps2_clock_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
         errors++;
         $display("FAIL reset_oe: clk_oe=%b data_oe=%b, required 0/0", ps2_clock_oe, ps2_data_oe);
      end
      bus_rd(1'b1);
      checks++;
      if (bus_data_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_status: got %h, required 00", bus_data_out);
      end
   endtask

   task automatic test_basic_rx();
      logic [7:0] codes [3];
      codes[0] = 8'h1C; codes[1] = 8'hF0; codes[2] = 8'h1C;
      for (int i = 0; i < 3; i++) push(codes[i], 1'b0);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_disabled: got %b, required 0", irq);
      end
      bus_rd(1'b1);
      checks++;
      if (bus_data_out !== 8'h01) begin
         errors++;
         $display("FAIL basic_status: got %h, required 01", bus_data_out);
      end
      for (int i = 0; i < 3; i++) begin
         bus_rd(1'b0);
         checks++;
         if (bus_data_out !== codes[i]) begin
            errors++;
            $display("FAIL basic_data%0d: got %h, required %h", i, bus_data_out, codes[i]);
         end
      end
      bus_rd(1'b1);
      checks++;
      if (bus_data_out !== 8'h00) begin
         errors++;
         $display("FAIL basic_status_empty: got %h, required 00", bus_data_out);
      end
   endtask

   task automatic test_empty_read();
      push(8'h5A, 1'b0);
      bus_rd(1'b0);
      checks++;
      if (bus_data_out !== 8'h5A) begin
         errors++;
         $display("FAIL empty_prefill: got %h, required 5a", bus_data_out);
      end
      bus_rd(1'b0);
      checks++;
      if (bus_data_out !== 8'h00) begin
         errors++;
         $display("FAIL empty_read: got %h, required 00", bus_data_out);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 17; i++) push(8'h40 + 8'(i), 1'b0);
      bus_rd(1'b1);
      checks++;
      if (bus_data_out !== 8'h03) begin
         errors++;
         $display("FAIL overflow_status: got %h, required 03", bus_data_out);
      end
      bus_rd(1'b1);
      checks++;
      if (bus_data_out !== 8'h01) begin
         errors++;
         $display("FAIL overflow_cleared: got %h, required 01", bus_data_out);
      end
      for (int i = 0; i < 16; i++) begin
         bus_rd(1'b0);
         checks++;
         if (bus_data_out !== 8'h40 + 8'(i)) begin
            errors++;
            $display("FAIL overflow_data%0d: got %h, required %h", i, bus_data_out, 8'h40 + 8'(i));
         end
      end
      bus_rd(1'b1);
      checks++;
      if (bus_data_out !== 8'h00) begin
         errors++;
         $display("FAIL overflow_drained: got %h, required 00", bus_data_out);
      end
   endtask

   task automatic test_parity();
      push(8'h66, 1'b1);
      bus_rd(1'b1);
      checks++;
      if (bus_data_out !== 8'h05) begin
         errors++;
         $display("FAIL parity_status: got %h, required 05", bus_data_out);
      end
      bus_rd(1'b1);
      checks++;
      if (bus_data_out !== 8'h01) begin
         errors++;
         $display("FAIL parity_cleared: got %h, required 01", bus_data_out);
      end
      bus_rd(1'b0);
      checks++;
      if (bus_data_out !== 8'h66) begin
         errors++;
         $display("FAIL parity_byte_kept: got %h, required 66", bus_data_out);
      end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 1'b0);
      tick();
      rx_scancode = 8'hAA;
      scancode_ready_set = 1'b1;
      bus_address = 1'b0;
      bus_read = 1'b1;
      tick();
      scancode_ready_set = 1'b0;
      bus_read = 1'b0;
      checks++;
      if (bus_data_out !== 8'h20) begin
         errors++;
         $display("FAIL fullpp_pop: got %h, required 20", bus_data_out);
      end
      bus_rd(1'b1);
      checks++;
      if (bus_data_out !== 8'h01) begin
         errors++;
         $display("FAIL fullpp_status: got %h, required 01", bus_data_out);
      end
      for (int i = 1; i < 16; i++) bus_rd(1'b0);
      checks++;
      if (bus_data_out !== 8'h2F) begin
         errors++;
         $display("FAIL fullpp_old_tail: got %h, required 2f", bus_data_out);
      end
      bus_rd(1'b0);
      checks++;
      if (bus_data_out !== 8'hAA) begin
         errors++;
         $display("FAIL fullpp_new_byte: got %h, required aa", bus_data_out);
      end
   endtask

   task automatic test_irq();
      bus_wr(1'b1, 8'h01);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_empty: got %b, required 0", irq);
      end
      push(8'h3B, 1'b0);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_set: got %b, required 1", irq);
      end
      bus_rd(1'b0);
      checks++;
      if (irq !== 1'b0 || bus_data_out !== 8'h3B) begin
         errors++;
         $display("FAIL irq_clear: irq=%b data=%h, required 0/3b", irq, bus_data_out);
      end
      bus_wr(1'b1, 8'h00);
   endtask

`ifdef PS2_HOST_TX_EN

   task automatic wait_request(output int unsigned n_inhibit, output bit ok);
      int unsigned guard = 0;
      n_inhibit = 0;
      while (ps2_data_oe !== 1'b1 && guard < 1000) begin
         @(negedge clock);
         if (ps2_clock_oe === 1'b1) n_inhibit++;
         guard++;
      end
      ok = (ps2_data_oe === 1'b1);
      #1;
   endtask

   task automatic test_tx(input logic [7:0] tx_byte, input logic parity_bit, input logic ack_bit,
                          input logic [7:0] exp_status);
      logic [9:0]  exp_line;
      int unsigned n_inhibit;
      bit          ok;
      exp_line = {1'b1, parity_bit, tx_byte};
      bus_wr(1'b0, tx_byte);
      wait_request(n_inhibit, ok);
      checks++;
      if (!ok || n_inhibit != Inhibit) begin
         errors++;
         $display("FAIL tx_inhibit_%h: request=%0d inhibit_cycles=%0d, required 1/%0d",
                  tx_byte, ok, n_inhibit, Inhibit);
      end
      checks++;
      if (ps2_clock_oe !== 1'b0 || ps2_data_oe !== 1'b1) begin
         errors++;
         $display("FAIL tx_start_%h: clk_oe=%b data_oe=%b, required 0/1",
                  tx_byte, ps2_clock_oe, ps2_data_oe);
      end
      bus_rd(1'b1);
      push(8'h77, 1'b0);
      checks++;
      if (bus_data_out !== 8'h08) begin
         errors++;
         $display("FAIL tx_busy_%h: got %h, required 08", tx_byte, bus_data_out);
      end
      for (int k = 0; k < 10; k++) begin
         ps2_clock_pulse();
         checks++;
         if (~ps2_data_oe !== exp_line[k]) begin
            errors++;
            $display("FAIL tx_bit_%h_edge%0d: line=%b, required %b",
                     tx_byte, k + 1, ~ps2_data_oe, exp_line[k]);
         end
      end
      ps2_data = ack_bit;
      ps2_clock_pulse();
      ps2_data = 1'b1;
      bus_rd(1'b1);
      checks++;
      if (bus_data_out !== exp_status || ps2_data_oe !== 1'b0) begin
         errors++;
         $display("FAIL tx_end_%h: status=%h data_oe=%b, required %h/0",
                  tx_byte, bus_data_out, ps2_data_oe, exp_status);
      end
      bus_rd(1'b1);
   endtask

   task automatic test_timeout();
      int unsigned n_inhibit, n_low = 0, guard = 0;
      bit          ok;
      bus_wr(1'b0, 8'hED);
      wait_request(n_inhibit, ok);
      while (ps2_data_oe === 1'b1 && guard < 2 * Timeout) begin
         @(negedge clock);
         if (ps2_data_oe === 1'b1) n_low++;
         guard++;
      end
      #1;
      // REQUEST cycle plus the full timeout window in SEND.
      checks++;
      if (!ok || n_low < Timeout || n_low > Timeout + 2) begin
         errors++;
         $display("FAIL timeout_window: data_oe cycles=%0d, required %0d..%0d",
                  n_low + 1, Timeout + 1, Timeout + 3);
      end
      checks++;
      if (ps2_clock_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
         errors++;
         $display("FAIL timeout_release: clk_oe=%b data_oe=%b, required 0/0",
                  ps2_clock_oe, ps2_data_oe);
      end
      bus_rd(1'b1);
      checks++;
      if (bus_data_out !== 8'h10) begin
         errors++;
         $display("FAIL timeout_status: got %h, required 10", bus_data_out);
      end
      bus_rd(1'b1);
      checks++;
      if (bus_data_out !== 8'h00) begin
         errors++;
         $display("FAIL timeout_cleared: got %h, required 00", bus_data_out);
      end
   endtask

   task automatic test_reset_mid_tx();
      int unsigned n_inhibit;
      bit          ok;
      push(8'h33, 1'b0);
      bus_wr(1'b0, 8'hA5);
      wait_request(n_inhibit, ok);
      repeat (3) ps2_clock_pulse();
      reset = 1'b1;
      tick();
      checks++;
      if (ps2_clock_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_tx: clk_oe=%b data_oe=%b, required 0/0",
                  ps2_clock_oe, ps2_data_oe);
      end
      reset = 1'b0;
      bus_rd(1'b1);
      checks++;
      if (bus_data_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid_tx_status: got %h, required 00", bus_data_out);
      end
   endtask

`else

   task automatic test_tx_disabled();
      int bad = 0;
      bus_wr(1'b0, 8'hED);
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (ps2_clock_oe !== 1'b0 || ps2_data_oe !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL txdis_oe: %0d cycles driven, required 0", bad);
      end
      bus_rd(1'b1);
      checks++;
      if (bus_data_out !== 8'h00) begin
         errors++;
         $display("FAIL txdis_status: got %h, required 00", bus_data_out);
      end
      push(8'h44, 1'b0);
      bus_rd(1'b0);
      checks++;
      if (bus_data_out !== 8'h44) begin
         errors++;
         $display("FAIL txdis_rx: got %h, required 44", bus_data_out);
      end
   endtask

`endif

   initial begin
      test_reset();
      test_basic_rx();
      test_empty_read();
      test_overflow();
      test_parity();
      test_full_push_pop();
      test_irq();
`ifdef PS2_HOST_TX_EN
      test_tx(8'hED, 1'b1, 1'b0, 8'h00);
      test_tx(8'hDA, 1'b0, 1'b1, 8'h10);
      test_timeout();
      test_reset_mid_tx();
`else
      test_tx_disabled();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
